// File: rtl/flop_test_pkg.sv
// Shared types, constants and LFSR step helper for capture-flop stimulus/check blocks.
package flop_test_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } fsm_state_t;

   localparam int unsigned DRAIN_CYCLES = 2;
   localparam int unsigned ERR_CNT_W    = 16;
   localparam int unsigned LFSR_MAX_W   = 64;

   // Galois step on a zero-extended state; callers truncate back to their width.
   function automatic logic [LFSR_MAX_W-1:0] lfsr_next(input logic [LFSR_MAX_W-1:0] s,
                                                       input logic [LFSR_MAX_W-1:0] taps);
      return (s >> 1) ^ (s[0] ? taps : '0);
   endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Galois LFSR with seed load and step enable; state is the registered output.
module lfsr_gen
   import flop_test_pkg::*;
#(
   parameter int unsigned     WIDTH = 8,
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   output logic [WIDTH-1:0] state
);

   localparam logic [WIDTH-1:0] SEED_NZ = (SEED == '0) ? WIDTH'(1) : SEED;

   // Resets to zero so a downstream consumer sees a quiet value until the first load.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= '0;
      end else if (load) begin
         state <= SEED_NZ;
      end else if (step) begin
         state <= WIDTH'(lfsr_next(LFSR_MAX_W'(state), LFSR_MAX_W'(TAPS)));
      end
   end

endmodule

// File: rtl/flop_stim_check.sv
// Drives an LFSR vector stream into a capture flop and checks its output one cycle later.
module flop_stim_check
   import flop_test_pkg::*;
#(
   parameter int unsigned      WIDTH       = 8,
   parameter int unsigned      NUM_VECTORS = 16,
   parameter logic [WIDTH-1:0] SEED        = WIDTH'(8'h01),
   parameter logic [WIDTH-1:0] TAPS        = WIDTH'(8'hB8)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   output logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     q,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic [ERR_CNT_W-1:0] first_err_idx,
   output logic [WIDTH-1:0]     first_err_data
);

   localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   fsm_state_t           state, state_nxt;
   logic [ERR_CNT_W-1:0] cur_idx;
   logic [DRAIN_W-1:0]   drain_cnt;
   logic [WIDTH-1:0]     exp_data;
   logic                 exp_v;
   logic [ERR_CNT_W-1:0] exp_idx;

   logic                 start_ok;
   logic                 last_issue;
   logic                 drain_last;
   logic                 mismatch;
   logic                 lfsr_load;
   logic                 lfsr_step;
   logic                 a_live;
   logic [ERR_CNT_W-1:0] err_count_nxt;
   logic                 busy_nxt;
   logic                 done_nxt;
   logic                 pass_nxt;

   assign start_ok   = start && ((state == IDLE) || (state == DONE));
   assign last_issue = ((17'(cur_idx) + 17'd2) == 17'(NUM_VECTORS));
   assign drain_last = (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1));
   assign mismatch   = exp_v && (q != exp_data);

   lfsr_gen #(
      .WIDTH (WIDTH),
      .SEED  (SEED),
      .TAPS  (TAPS)
   ) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .load  (lfsr_load),
      .step  (lfsr_step),
      .state (a)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE, DONE: if (start) state_nxt = (NUM_VECTORS == 1) ? DRAIN : RUN;
         RUN:        if (last_issue) state_nxt = DRAIN;
         DRAIN:      if (drain_last) state_nxt = DONE;
         default:    state_nxt = IDLE;
      endcase
   end

   // The vector on a is live for every RUN cycle plus the first DRAIN cycle.
   always_comb begin
      lfsr_load     = 1'b0;
      lfsr_step     = 1'b0;
      a_live        = 1'b0;
      err_count_nxt = err_count;
      busy_nxt      = 1'b0;
      done_nxt      = 1'b0;
      pass_nxt      = 1'b0;

      lfsr_load = start_ok;
      lfsr_step = (state == RUN);
      a_live    = (state == RUN) || ((state == DRAIN) && (drain_cnt == '0));

      if (start_ok) begin
         err_count_nxt = '0;
      end else if (mismatch && (err_count != '1)) begin
         err_count_nxt = err_count + ERR_CNT_W'(1);
      end

      busy_nxt = (state_nxt == RUN) || (state_nxt == DRAIN);
      done_nxt = (state_nxt == DONE);
      pass_nxt = done_nxt && (err_count_nxt == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cur_idx        <= '0;
         drain_cnt      <= '0;
         exp_data       <= '0;
         exp_v          <= 1'b0;
         exp_idx        <= '0;
         err_count      <= '0;
         first_err_idx  <= '1;
         first_err_data <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
      end else begin
         busy      <= busy_nxt;
         done      <= done_nxt;
         pass      <= pass_nxt;
         err_count <= err_count_nxt;
         exp_data  <= a;
         exp_v     <= a_live;
         exp_idx   <= cur_idx;
         drain_cnt <= (state == DRAIN) ? drain_cnt + DRAIN_W'(1) : '0;

         if (start_ok)            cur_idx <= '0;
         else if (state == RUN)   cur_idx <= cur_idx + ERR_CNT_W'(1);

         // A zero count before this compare marks the first mismatch of the run.
         if (start_ok) begin
            first_err_idx  <= '1;
            first_err_data <= '0;
         end else if (mismatch && (err_count == '0)) begin
            first_err_idx  <= exp_idx;
            first_err_data <= q;
         end
      end
   end

endmodule

// File: tb/tb_flop_stim_check.sv
// Randomized scoreboard bench for flop_stim_check driving a modelled capture flop.
module tb_flop_stim_check;

   localparam int unsigned W    = 8;
   localparam int unsigned NV   = 4;
   localparam logic [W-1:0] SEED = 8'h01;
   localparam logic [W-1:0] TAPS = 8'hB8;

   typedef struct {
      logic [15:0]  err;
      logic [15:0]  fidx;
      logic [W-1:0] fdata;
      logic         pass;
   } res_t;

   logic         clk    = 1'b0;
   logic         reset  = 1'b1;
   logic         start  = 1'b0;
   logic         stuck  = 1'b0;
   logic [W-1:0] q_flop = '0;
   logic [W-1:0] q_mask = '0;
   logic [W-1:0] a, q;
   logic         busy, done, pass;
   logic [15:0]  err_count, first_err_idx;
   logic [W-1:0] first_err_data;

   logic [W-1:0] exp_a_q [$];
   res_t         exp_res_q [$];
   logic [W-1:0] mask [NV];

   int   n_cmp    = 0;
   int   n_bad    = 0;
   int   busy_cyc = 0;
   logic done_d   = 1'b0;

   flop_stim_check #(
      .WIDTH       (W),
      .NUM_VECTORS (NV),
      .SEED        (SEED),
      .TAPS        (TAPS)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .a              (a),
      .q              (q),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .err_count      (err_count),
      .first_err_idx  (first_err_idx),
      .first_err_data (first_err_data)
   );

   always #5 clk = ~clk;

   // Flop under test: ideal capture, optionally stuck at zero or corrupted per compare cycle.
   always @(posedge clk) q_flop <= a;
   assign q = stuck ? '0 : (q_flop ^ q_mask);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_a"},        32'(a), 32'h0);
      check({tag, "_busy"},     32'(busy), 32'h0);
      check({tag, "_done"},     32'(done), 32'h0);
      check({tag, "_pass"},     32'(pass), 32'h0);
      check({tag, "_err"},      32'(err_count), 32'h0);
      check({tag, "_fidx"},     32'(first_err_idx), 32'hFFFF);
      check({tag, "_fdata"},    32'(first_err_data), 32'h0);
   endtask

   task automatic clear_masks();
      for (int i = 0; i < NV; i++) mask[i] = '0;
   endtask

   // Monitor: checks each issued vector on a, then the result summary when done rises.
   always @(negedge clk) begin
      res_t r;
      if (reset) begin
         busy_cyc = 0;
         done_d   = 1'b0;
      end else begin
         if (busy) begin
            if (busy_cyc < NV) begin
               if (exp_a_q.size() == 0) check("a_unexpected", 32'(a), 32'hDEAD);
               else                     check("a_vec", 32'(a), 32'(exp_a_q.pop_front()));
            end
            busy_cyc++;
         end
         if (done && !done_d) begin
            check("run_len", 32'(busy_cyc), 32'(NV + 1));
            if (exp_res_q.size() == 0) begin
               check("res_unexpected", 32'(err_count), 32'hDEAD);
            end else begin
               r = exp_res_q.pop_front();
               check("err_count",      32'(err_count), 32'(r.err));
               check("first_err_idx",  32'(first_err_idx), 32'(r.fidx));
               check("first_err_data", 32'(first_err_data), 32'(r.fdata));
               check("pass",           32'(pass), 32'(r.pass));
            end
            busy_cyc = 0;
         end
         done_d = done;
      end
   end

   // One run: build expectations from the LFSR rule and flop behaviour, then drive it.
   task automatic run(input bit stuck_mode, input bit poke, input bit abort);
      logic [W-1:0] v;
      logic [W-1:0] obs;
      res_t         r;
      v       = SEED;
      r.err   = '0;
      r.fidx  = 16'hFFFF;
      r.fdata = '0;
      for (int i = 0; i < NV; i++) begin
         exp_a_q.push_back(v);
         obs = stuck_mode ? '0 : (v ^ mask[i]);
         if (obs != v) begin
            if (r.err == 0) begin
               r.fidx  = 16'(i);
               r.fdata = obs;
            end
            r.err = r.err + 16'd1;
         end
         v = (v >> 1) ^ (v[0] ? TAPS : '0);
      end
      r.pass = (r.err == 0);
      exp_res_q.push_back(r);

      @(negedge clk);
      stuck = stuck_mode;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= NV + 1; c++) begin
         @(posedge clk); #1;
         if (c - 1 < NV) q_mask = mask[c-1];
         else            q_mask = '0;
         start = poke && (c == 1);
         if (abort && c == 1) begin
            reset = 1'b1;
            @(posedge clk); #1;
            check_reset("mid_rst");
            reset  = 1'b0;
            start  = 1'b0;
            q_mask = '0;
            stuck  = 1'b0;
            exp_a_q.delete();
            exp_res_q.delete();
            return;
         end
      end
      check("done_at_end", 32'(done), 32'h1);
      q_mask = '0;
      @(negedge clk); #1;
      stuck = 1'b0;
   endtask

   initial begin
      clear_masks();
      repeat (3) @(posedge clk);
      #1;
      check_reset("por");
      reset = 1'b0;

      run(1'b0, 1'b0, 1'b0);
      run(1'b0, 1'b1, 1'b0);
      run(1'b1, 1'b0, 1'b0);
      mask[2] = 8'h01;
      run(1'b0, 1'b0, 1'b0);
      clear_masks();
      run(1'b0, 1'b0, 1'b0);
      run(1'b0, 1'b0, 1'b1);
      run(1'b0, 1'b0, 1'b0);

      for (int n = 0; n < 25; n++) begin
         int mode;
         mode = int'($urandom_range(0, 3));
         clear_masks();
         if (mode >= 2) begin
            for (int i = 0; i < NV; i++)
               if ($urandom_range(0, 2) == 0) mask[i] = W'($urandom_range(1, 255));
         end
         repeat ($urandom_range(0, 3)) @(posedge clk);
         run(mode == 1, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
      end
      clear_masks();

      repeat (4) @(posedge clk);
      #1;
      check("a_queue_empty",   32'(exp_a_q.size()), 32'h0);
      check("res_queue_empty", 32'(exp_res_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
